// File: rtl/pipeline_interlock_ctrl.sv
// pipeline_interlock_ctrl
//  Hazard interlock for the 5-stage SimpleRISC pipeline (IF, OF, EX, MA, RW).
//  A shadow of the destination / flag-write info of the instructions in EX
//  and MA is compared against the sources of the instruction waiting in the
//  IF/OF latch. The result drives PC / IF-OF stall, EX bubble insertion,
//  branch flush and the memory-busy freeze, and a saturating counter of
//  hazard-stall cycles for performance monitoring.
//
//  Build option PIPE_FORWARDING_EN:
//   defined   - the datapath forwards EX/MA/RW results and flags, so only a
//               load in EX feeding the OF instruction interlocks (1 cycle).
//   undefined - every register or flag RAW match against EX or MA stalls
//               (at most 2 cycles).

module pipeline_interlock_ctrl #(
  parameter int REG_W       = 4,
  parameter int RA_REG      = 15,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            of_instr,
  input  logic                   of_valid,
  input  logic                   branch_taken,
  input  logic                   ma_busy,
  output logic                   stall_pc,
  output logic                   stall_of,
  output logic                   bubble_ex,
  output logic                   flush_if,
  output logic                   freeze,
  output logic [STALL_CNT_W-1:0] stall_count
);

  // ---------------------------------------------------------------------------
  // Opcodes that need special treatment; anything else is a plain ALU op
  // (reads rs1, reads rs2 unless immediate, writes rd).
  // ---------------------------------------------------------------------------
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_NOT  = 5'b01000;
  localparam logic [4:0] OP_MOV  = 5'b01001;
  localparam logic [4:0] OP_NOP  = 5'b01101;
  localparam logic [4:0] OP_LD   = 5'b01110;
  localparam logic [4:0] OP_ST   = 5'b01111;
  localparam logic [4:0] OP_BEQ  = 5'b10000;
  localparam logic [4:0] OP_BGT  = 5'b10001;
  localparam logic [4:0] OP_B    = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET  = 5'b10100;

  localparam logic [REG_W-1:0] RA_IDX = REG_W'(RA_REG);

`ifdef PIPE_FORWARDING_EN
  // Results and flags are forwarded; only a load still in EX is too late.
  localparam bit LOAD_USE_ONLY = 1'b1;
`else
  // No forwarding: any producer still in EX or MA blocks the consumer.
  localparam bit LOAD_USE_ONLY = 1'b0;
`endif

  // What an in-flight instruction will write.
  typedef struct packed {
    logic             valid;
    logic             wr;
    logic [REG_W-1:0] dest;
    logic             is_ld;
    logic             wr_flags;
  } ex_entry_t;

  // The load flag is dropped once the instruction leaves EX: nothing
  // compares against it in MA.
  typedef struct packed {
    logic             valid;
    logic             wr;
    logic [REG_W-1:0] dest;
    logic             wr_flags;
  } ma_entry_t;

  // What the OF instruction reads: up to three registers plus the flags.
  typedef struct packed {
    logic             use1;
    logic [REG_W-1:0] idx1;
    logic             use2;
    logic [REG_W-1:0] idx2;
    logic             use3;
    logic [REG_W-1:0] idx3;
    logic             rd_flags;
  } src_t;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [4:0]       op;
  logic             imm;
  logic [REG_W-1:0] f_rd;
  logic [REG_W-1:0] f_rs1;
  logic [REG_W-1:0] f_rs2;
  logic             unused_imm_bits;

  assign op    = of_instr[31:27];
  assign imm   = of_instr[26];
  assign f_rd  = of_instr[25 -: REG_W];
  assign f_rs1 = of_instr[21 -: REG_W];
  assign f_rs2 = of_instr[17 -: REG_W];
  // Immediate / offset bits carry no register information.
  assign unused_imm_bits = ^of_instr[13:0];

  // ---------------------------------------------------------------------------
  // State and internal signals
  // ---------------------------------------------------------------------------
  ex_entry_t ex_q;
  ma_entry_t ma_q;
  ex_entry_t of_dec;
  src_t      of_src;

  logic ex_reg_hit;
  logic ma_reg_hit;
  logic ex_flag_hit;
  logic ma_flag_hit;
  logic hazard;
  logic hazard_stall;
  logic issue;

  logic [STALL_CNT_W-1:0] stall_cnt_q;

  // True when any register source of s equals destination d.
  function automatic logic reads_reg(input src_t s, input logic [REG_W-1:0] d);
    return (s.use1 && (s.idx1 == d)) ||
           (s.use2 && (s.idx2 == d)) ||
           (s.use3 && (s.idx3 == d));
  endfunction

  // Decode the OF instruction into its source set and its shadow entry.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    of_src      = '0;
    of_dec      = '0;
    of_src.idx1 = f_rs1;
    of_src.idx2 = f_rs2;
    of_src.idx3 = f_rd;
    of_dec.dest = f_rd;
    case (op)
      OP_NOP, OP_B: begin
      end
      OP_BEQ, OP_BGT: begin
        of_src.rd_flags = 1'b1;
      end
      OP_CALL: begin
        // Return address goes to the link register, not to rd.
        of_dec.wr   = 1'b1;
        of_dec.dest = RA_IDX;
      end
      OP_RET: begin
        // Jumps through the link register.
        of_src.use1 = 1'b1;
        of_src.idx1 = RA_IDX;
      end
      OP_NOT, OP_MOV: begin
        of_src.use2 = !imm;
        of_dec.wr   = 1'b1;
      end
      OP_LD: begin
        of_src.use1  = 1'b1;
        of_dec.wr    = 1'b1;
        of_dec.is_ld = 1'b1;
      end
      OP_ST: begin
        // The store data register sits in the rd field.
        of_src.use1 = 1'b1;
        of_src.use2 = !imm;
        of_src.use3 = 1'b1;
      end
      OP_CMP: begin
        of_src.use1     = 1'b1;
        of_src.use2     = !imm;
        of_dec.wr_flags = 1'b1;
      end
      default: begin
        of_src.use1 = 1'b1;
        of_src.use2 = !imm;
        of_dec.wr   = 1'b1;
      end
    endcase
    of_dec.valid = of_valid;
  end

  // Compare OF sources against the producers shadowed in EX and MA.
  always_comb begin
    ex_reg_hit  = ex_q.valid && ex_q.wr && reads_reg(of_src, ex_q.dest);
    ma_reg_hit  = ma_q.valid && ma_q.wr && reads_reg(of_src, ma_q.dest);
    ex_flag_hit = ex_q.valid && ex_q.wr_flags && of_src.rd_flags;
    ma_flag_hit = ma_q.valid && ma_q.wr_flags && of_src.rd_flags;
    if (LOAD_USE_ONLY) begin
      hazard = of_valid && ex_q.is_ld && ex_reg_hit;
    end else begin
      hazard = of_valid && (ex_reg_hit || ma_reg_hit || ex_flag_hit || ma_flag_hit);
    end
    // A hazard only stalls when neither a freeze nor a flush overrides it.
    hazard_stall = !ma_busy && !branch_taken && hazard;
    issue        = of_valid && !hazard && !branch_taken;
  end

  // Age the shadow one stage per advancing clock; hold it while memory is busy.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: only this handful of state flops exists, so all of it is reset;
    // the valid bits are what matter, the rest just keeps the state tidy.
    if (rst) begin
      ex_q <= '0;
      ma_q <= '0;
    end else if (!ma_busy) begin
      // NOTE: non-blocking assignments make MA pick up the old EX value while
      // EX loads the new one, independent of statement order.
      ma_q.valid    <= ex_q.valid;
      ma_q.wr       <= ex_q.wr;
      ma_q.dest     <= ex_q.dest;
      ma_q.wr_flags <= ex_q.wr_flags;
      ex_q          <= issue ? of_dec : '0;
    end
  end

  // Count cycles lost to genuine hazard stalls; stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (hazard_stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_count = stall_cnt_q;

  // Pipeline controls: freeze beats flush beats hazard; all quiet in reset.
  always_comb begin
    stall_pc  = 1'b0;
    stall_of  = 1'b0;
    bubble_ex = 1'b0;
    flush_if  = 1'b0;
    freeze    = 1'b0;
    if (!rst) begin
      if (ma_busy) begin
        freeze   = 1'b1;
        stall_pc = 1'b1;
        stall_of = 1'b1;
      end else if (branch_taken) begin
        flush_if  = 1'b1;
        bubble_ex = 1'b1;
      end else if (hazard) begin
        stall_pc  = 1'b1;
        stall_of  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

endmodule
